pe_rx_depacketizer: RTL and testbench

PE_RX_DEPACKETIZER -- requirements
Module: pe_rx_depacketizer

---
 rtl/noc_pkg.sv | 21 ++
 rtl/noc_sat_counter.sv | 21 ++
 rtl/pe_rx_depacketizer.sv | 96 +++++++++
 tb/tb_pe_rx_depacketizer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: field widths, packet bit positions and the
// receive-side FSM state type used by the PE depacketizer.
package noc_pkg;

  localparam int unsigned ID_W     = 2;
  localparam int unsigned PAY_W    = 4;
  localparam int unsigned PKT_W    = 8;

  // Packet layout: [7:6] src, [5:4] dest, [3:0] payload
  localparam int unsigned SRC_LSB  = 6;
  localparam int unsigned DEST_LSB = 4;
  localparam int unsigned PAY_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } rx_state_t;

endpackage

// File: rtl/noc_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
// Holds at all-ones once reached; never wraps.
module noc_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stop at the maximum value, clear has priority
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pe_rx_depacketizer.sv
// PE receive depacketizer: pops one packet at a time from the local FIFO,
// delivers packets addressed to MY_ID through a valid/ready handshake and
// drops the rest.
// Optional macro NOC_RX_MISROUTE_CNT_EN: when defined, dropped packets are
// counted on misroute_count; otherwise that port is tied to zero.
module pe_rx_depacketizer
  import noc_pkg::*;
#(
  parameter logic [ID_W-1:0] MY_ID = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [PKT_W-1:0] fifo_data,
  output logic [PAY_W-1:0] rx_data,
  output logic [ID_W-1:0]  rx_src,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       pkt_count,
  output logic [7:0]       misroute_count,
  output logic             busy
);

  rx_state_t state;
  logic      dest_match;
  logic      pkt_inc;

  assign dest_match = (fifo_data[DEST_LSB +: ID_W] == MY_ID);
  assign pkt_inc    = (state == HOLD) && rx_ready;
  assign busy       = (state != IDLE);

  // Receive FSM with registered FIFO pop strobe and delivery outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_src     <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
          end
        end
        POP: begin
          state <= CAPT;
        end
        CAPT: begin
          if (dest_match) begin
            rx_data  <= fifo_data[PAY_LSB +: PAY_W];
            rx_src   <= fifo_data[SRC_LSB +: ID_W];
            rx_valid <= 1'b1;
            state    <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  noc_sat_counter #(.W(8)) u_pkt_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (pkt_inc),
    .count (pkt_count)
  );

`ifdef NOC_RX_MISROUTE_CNT_EN
  logic misroute_inc;

  assign misroute_inc = (state == CAPT) && !dest_match;

  noc_sat_counter #(.W(8)) u_misroute_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (misroute_inc),
    .count (misroute_count)
  );
`else
  assign misroute_count = 8'h00;
`endif

endmodule

// File: tb/tb_pe_rx_depacketizer.sv
// Self-checking bench for pe_rx_depacketizer (MY_ID = 2'b01).
// The reference tracks the receiver as a timeline: the cycle a pop is
// expected, the capture cycle, when delivery starts and when the block is
// free again, plus saturating packet/misroute tallies.
module tb_pe_rx_depacketizer;

  localparam logic [1:0] ID  = 2'b01;
  localparam int         BIG = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = '0;
  logic [3:0] rx_data;
  logic [1:0] rx_src;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] pkt_count;
  logic [7:0] misroute_count;
  logic       busy;

  pe_rx_depacketizer #(.MY_ID(ID)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data      (fifo_data),
    .rx_data        (rx_data),
    .rx_src         (rx_src),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .pkt_count      (pkt_count),
    .misroute_count (misroute_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus segment: rst_m 0 off / 1 on / 2 rare random;
  // empty_m 0 has-data / 1 empty / 2 random / 3 toggle;
  // ready_m 0 low / 1 high / 2 random;
  // pkt_m 0 fixed / 1 random / 2 random addressed to us / 3 random misrouted
  typedef struct {
    int         cycles;
    int         rst_m;
    int         empty_m;
    int         ready_m;
    int         pkt_m;
    logic [7:0] pkt;
    bit         strict_gap;
  } seg_t;

  seg_t segs[$];

  function automatic seg_t mk(int cyc, int r, int e, int rd, int p, logic [7:0] pk, bit sg);
    seg_t s;
    s.cycles = cyc; s.rst_m = r; s.empty_m = e; s.ready_m = rd;
    s.pkt_m = p; s.pkt = pk; s.strict_gap = sg;
    return s;
  endfunction

  function automatic logic [7:0] gen_pkt(int mode, logic [7:0] fixed);
    logic [7:0] p;
    p = 8'($urandom);
    case (mode)
      0: p = fixed;
      2: p[5:4] = ID;
      3: p[5:4] = ID ^ 2'($urandom_range(1, 3));
      default: ;
    endcase
    return p;
  endfunction

  initial begin
    int         c;
    int         idle_from, next_pop, capt_cyc, valid_from, last_rd;
    logic [7:0] cur_pkt, cap_pkt, m_pkt, m_mis;
    logic       exp_valid, r_in, e_in, rd_in, after_rst;

    segs.push_back(mk(3,    1, 1, 0, 0, 8'h00, 0));  // reset
    segs.push_back(mk(4,    0, 1, 1, 0, 8'h00, 0));  // idle, nothing queued
    segs.push_back(mk(3,    0, 0, 1, 0, 8'h9A, 0));  // src=2 dest=1 payload=A
    segs.push_back(mk(6,    0, 1, 1, 0, 8'h00, 0));
    segs.push_back(mk(3,    0, 0, 1, 0, 8'h35, 0));  // dest=3: dropped
    segs.push_back(mk(6,    0, 1, 1, 0, 8'h00, 0));
    segs.push_back(mk(14,   0, 0, 0, 0, 8'h5D, 0));  // stall in delivery
    segs.push_back(mk(10,   0, 0, 1, 0, 8'h5D, 0));
    segs.push_back(mk(1250, 0, 0, 1, 2, 8'h00, 1));  // >255 deliveries
    segs.push_back(mk(900,  0, 0, 1, 3, 8'h00, 0));  // >255 drops
    segs.push_back(mk(6,    0, 0, 0, 2, 8'h00, 0));  // held packet...
    segs.push_back(mk(1,    1, 0, 0, 2, 8'h00, 0));  // ...killed by reset
    segs.push_back(mk(8,    0, 1, 1, 2, 8'h00, 0));
    segs.push_back(mk(200,  0, 3, 2, 1, 8'h00, 0));  // toggling empty
    segs.push_back(mk(2000, 2, 2, 2, 1, 8'h00, 0));  // fully random

    c = 0; idle_from = 0; next_pop = -1; capt_cyc = -1; valid_from = -1;
    last_rd = -1; cur_pkt = '0; cap_pkt = '0; m_pkt = '0; m_mis = '0;
    after_rst = 1'b0;

    foreach (segs[si]) begin
      for (int k = 0; k < segs[si].cycles; k++) begin
        @(negedge clk);
        exp_valid = (valid_from >= 0) && (c >= valid_from);
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(c == next_pop));
        chk("rx_valid", 32'(rx_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(c < idle_from));
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
        chk("misroute_count", 32'(misroute_count), 32'(m_mis));
        if (exp_valid) begin
          chk("rx_data", 32'(rx_data), 32'(cap_pkt[3:0]));
          chk("rx_src", 32'(rx_src), 32'(cap_pkt[7:6]));
        end
        if (after_rst) begin
          chk("rst_rx_data", 32'(rx_data), 32'h0);
          chk("rst_rx_src", 32'(rx_src), 32'h0);
          after_rst = 1'b0;
        end
        if (fifo_rd_en === 1'b1) begin
          if (segs[si].strict_gap && last_rd >= 0)
            chk("pop_spacing", 32'(c - last_rd), 32'd4);
          last_rd = c;
        end

        r_in = (segs[si].rst_m == 1) ||
               (segs[si].rst_m == 2 && $urandom_range(0, 199) == 0);
        case (segs[si].empty_m)
          0:       e_in = 1'b0;
          1:       e_in = 1'b1;
          3:       e_in = 1'(c % 2);
          default: e_in = 1'($urandom_range(0, 1));
        endcase
        case (segs[si].ready_m)
          0:       rd_in = 1'b0;
          1:       rd_in = 1'b1;
          default: rd_in = 1'($urandom_range(0, 1));
        endcase

        rst        = r_in;
        fifo_empty = e_in;
        rx_ready   = rd_in;
        fifo_data  = (c == capt_cyc) ? cur_pkt : 8'($urandom);

        if (r_in) begin
          idle_from = c + 1; next_pop = -1; capt_cyc = -1; valid_from = -1;
          m_pkt = '0; m_mis = '0; last_rd = -1; after_rst = 1'b1;
        end else begin
          if (exp_valid && rd_in) begin
            if (m_pkt != 8'hFF) m_pkt = m_pkt + 8'd1;
            valid_from = -1;
            idle_from  = c + 1;
          end
          if (c == capt_cyc) begin
            if (cur_pkt[5:4] == ID) begin
              cap_pkt    = cur_pkt;
              valid_from = c + 1;
            end else begin
`ifdef NOC_RX_MISROUTE_CNT_EN
              if (m_mis != 8'hFF) m_mis = m_mis + 8'd1;
`endif
              idle_from = c + 1;
            end
            capt_cyc = -1;
          end
          if (c == next_pop) begin
            cur_pkt  = gen_pkt(segs[si].pkt_m, segs[si].pkt);
            capt_cyc = c + 1;
            next_pop = -1;
          end
          if (c >= idle_from && !e_in) begin
            next_pop  = c + 1;
            idle_from = BIG;
          end
        end
        c++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
